// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: M-extension funct3 codes and the multiplier FSM state type.
package tinyriscv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_END  = 2'd2,
        MUL_ZERO = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies magnitudes, then negates the full double-width product when needed.
module mul_iter
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mlr;
    logic               r_neg;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_ready;

    logic               w_mcand_sgn;
    logic               w_mlr_sgn;
    logic               w_zero;
    logic [WIDTH-1:0]   w_mcand_mag;
    logic [WIDTH-1:0]   w_mlr_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_sel;

    assign w_mcand_sgn = ((op_i == INST_MULH) || (op_i == INST_MULHSU)) && multiplicand_i[WIDTH-1];
    assign w_mlr_sgn   = (op_i == INST_MULH) && multiplier_i[WIDTH-1];
    assign w_mcand_mag = w_mcand_sgn ? (~multiplicand_i + 1'b1) : multiplicand_i;
    assign w_mlr_mag   = w_mlr_sgn ? (~multiplier_i + 1'b1) : multiplier_i;
    assign w_zero      = (multiplicand_i == '0) || (multiplier_i == '0);

    // W+1-bit add into the upper half; the carry is shifted back in below.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_mlr[0] ? r_mcand : '0)};
    assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= MUL_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!valid_i) begin
            w_state_nxt = MUL_IDLE;
        end else begin
            unique case (r_state)
                MUL_IDLE: w_state_nxt = w_zero ? MUL_ZERO : MUL_CALC;
                MUL_CALC: w_state_nxt = (r_cnt == '0) ? MUL_END : MUL_CALC;
                MUL_END:  w_state_nxt = MUL_IDLE;
                MUL_ZERO: w_state_nxt = MUL_IDLE;
                default:  w_state_nxt = MUL_IDLE;
            endcase
        end
    end

    always_comb begin
        w_res_sel = '0;
        case (r_op)
            INST_MUL:                            w_res_sel = w_prod[WIDTH-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU:  w_res_sel = w_prod[2*WIDTH-1:WIDTH];
            default:                             w_res_sel = '0;
        endcase
    end

    // Dropping valid_i aborts and clears everything except the last result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mlr    <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (!valid_i) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mlr    <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                MUL_IDLE: begin
                    r_op    <= op_i;
                    r_mcand <= w_mcand_mag;
                    r_mlr   <= w_mlr_mag;
                    r_neg   <= w_mcand_sgn ^ w_mlr_sgn;
                    r_acc   <= '0;
                    r_cnt   <= CNT_W'(WIDTH - 1);
                    r_ready <= 1'b0;
                end
                MUL_CALC: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mlr <= r_mlr >> 1;
                    r_cnt <= r_cnt - 1'b1;
                end
                MUL_END: begin
                    r_result <= w_res_sel;
                    r_ready  <= 1'b1;
                end
                MUL_ZERO: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
